// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, field widths and score arithmetic for the round sequencer
package game_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAUNCH   = 3'd1,
        WAIT_SCR = 3'd2,
        PLAY     = 3'd3,
        JUDGE    = 3'd4,
        RESULT   = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam int ROUND_W   = 4;
    localparam int TIME_W    = 6;
    localparam int SCORE_W   = 4;
    localparam int TRIES_W   = 2;
    localparam int SCORE_MAX = 15;

    // SCORE_MAX is all-ones, so a carry out of the score field means saturate
    function automatic logic [SCORE_W-1:0] score_sat_add(input logic [SCORE_W-1:0] a,
                                                         input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - player/datapath handshake and display signals of the round sequencer
interface round_sequencer_if;
    import game_pkg::*;

    logic               start_btn;
    logic               submit_btn;
    logic               scramble_done;
    logic               is_correct;
    logic               game_start;
    logic [ROUND_W-1:0] round_num;
    logic [TIME_W-1:0]  time_left;
    logic [SCORE_W-1:0] score;
    logic [TRIES_W-1:0] tries_left;
    logic               round_win;
    logic               round_lose;
    logic               game_over;

    modport slave (
        input  start_btn, submit_btn, scramble_done, is_correct,
        output game_start, round_num, time_left, score, tries_left,
               round_win, round_lose, game_over
    );

    modport master (
        output start_btn, submit_btn, scramble_done, is_correct,
        input  game_start, round_num, time_left, score, tries_left,
               round_win, round_lose, game_over
    );

endinterface

// File: rtl/round_timer.sv
// rtl/round_timer.sv - per-round seconds countdown driven by a clock prescaler
module round_timer
    import game_pkg::*;
#(
    parameter int ROUND_TIME = 30,
    parameter int TICK_DIV   = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_run,
    output logic [TIME_W-1:0] o_time_left,
    output logic              o_timeout
);

    localparam int                PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] TIME_INIT = TIME_W'(ROUND_TIME);

    logic [PRE_W-1:0]  r_presc;
    logic [TIME_W-1:0] r_time;
    logic              w_wrap;

    assign w_wrap      = i_run && (r_presc == PRE_LAST);
    assign o_timeout   = w_wrap && (r_time == TIME_W'(1));
    assign o_time_left = r_time;

    // Holding i_run low freezes both counters so a resumed round keeps its phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= '0;
            r_time  <= TIME_INIT;
        end else if (i_load) begin
            r_presc <= '0;
            r_time  <= TIME_INIT;
        end else if (w_wrap) begin
            r_presc <= '0;
            r_time  <= r_time - TIME_W'(1);
        end else if (i_run) begin
            r_presc <= r_presc + PRE_W'(1);
        end
    end

endmodule

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game FSM: launch, scramble wait, timed play, judging and scoring (option: SCORE_BONUS_EN)
module round_sequencer
    import game_pkg::*;
#(
    parameter int NUM_ROUNDS  = 5,
    parameter int ROUND_TIME  = 30,
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_TRIES   = 3,
    parameter int RESULT_HOLD = 100000000
) (
    input  logic              clk,
    input  logic              rst,
    round_sequencer_if.slave  bus
);

    localparam int                 HOLD_W    = $clog2(RESULT_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);
    localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NUM_ROUNDS);

    state_t             r_state;
    state_t             w_next;
    logic [ROUND_W-1:0] r_round;
    logic [SCORE_W-1:0] r_score;
    logic [TRIES_W-1:0] r_tries;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_win;
    logic               r_lose;

    logic               w_load;
    logic               w_run;
    logic               w_timeout;
    logic               w_hold_done;
    logic [TIME_W-1:0]  w_time_left;
    logic [SCORE_W-1:0] w_gain;

    // Reloads land on entry to LAUNCH so the launch cycle already shows fresh values
    assign w_load      = (w_next == LAUNCH);
    assign w_run       = (r_state == PLAY) && !bus.submit_btn;
    assign w_hold_done = (r_state == RESULT) && (r_hold == HOLD_LAST);

    round_timer #(
        .ROUND_TIME (ROUND_TIME),
        .TICK_DIV   (TICK_DIV)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_run       (w_run),
        .o_time_left (w_time_left),
        .o_timeout   (w_timeout)
    );

`ifdef SCORE_BONUS_EN
    assign w_gain = ((w_time_left >= TIME_W'(ROUND_TIME / 2)) && (r_tries == TRIES_MAX))
                    ? SCORE_W'(2) : SCORE_W'(1);
`else
    assign w_gain = SCORE_W'(1);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.start_btn) w_next = LAUNCH;
            LAUNCH:   w_next = WAIT_SCR;
            WAIT_SCR: if (bus.scramble_done) w_next = PLAY;
            PLAY: begin
                if (bus.submit_btn)  w_next = JUDGE;
                else if (w_timeout)  w_next = RESULT;
            end
            JUDGE:    w_next = (bus.is_correct || (r_tries <= TRIES_W'(1))) ? RESULT : PLAY;
            RESULT:   if (w_hold_done) w_next = (r_round == LAST_RND) ? DONE : LAUNCH;
            DONE:     if (bus.start_btn) w_next = LAUNCH;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_round <= ROUND_W'(1);
            r_score <= '0;
            r_tries <= TRIES_MAX;
            r_hold  <= '0;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_win   <= 1'b0;
            r_lose  <= 1'b0;
            if (w_load) r_tries <= TRIES_MAX;
            case (r_state)
                PLAY: if (w_timeout) r_lose <= 1'b1;
                JUDGE: begin
                    if (bus.is_correct) begin
                        r_score <= score_sat_add(r_score, w_gain);
                        r_win   <= 1'b1;
                    end else if (r_tries > TRIES_W'(1)) begin
                        r_tries <= r_tries - TRIES_W'(1);
                    end else begin
                        r_tries <= '0;
                        r_lose  <= 1'b1;
                    end
                end
                RESULT: begin
                    if (w_hold_done) begin
                        r_hold <= '0;
                        if (r_round != LAST_RND) r_round <= r_round + ROUND_W'(1);
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                    end
                end
                DONE: begin
                    if (bus.start_btn) begin
                        r_score <= '0;
                        r_round <= ROUND_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.game_start = (r_state == LAUNCH);
    assign bus.game_over  = (r_state == DONE);
    assign bus.round_num  = r_round;
    assign bus.time_left  = w_time_left;
    assign bus.score      = r_score;
    assign bus.tries_left = r_tries;
    assign bus.round_win  = r_win;
    assign bus.round_lose = r_lose;

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - vector table, corner sequences and random run against a game-level model
module tb_round_sequencer;
    import game_pkg::*;

    localparam int NR = 2, RT = 3, TD = 4, MT = 2, RH = 2;
    localparam int P_IDLE = 0, P_LAUNCH = 1, P_WAIT = 2, P_PLAY = 3, P_JUDGE = 4, P_RESULT = 5, P_DONE = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    round_sequencer_if bus ();

    round_sequencer #(
        .NUM_ROUNDS (NR), .ROUND_TIME (RT), .TICK_DIV (TD), .MAX_TRIES (MT), .RESULT_HOLD (RH)
    ) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    always #5 clk = ~clk;

    // Game-level model: time is derived from PLAY cycles elapsed, not from a prescaler
    int m_phase, m_elapsed, m_round, m_score, m_tries, m_hold, m_win, m_lose;

    function automatic logic [19:0] ex(input int gs, input int rn, input int tl, input int sc,
                                       input int tr, input int w, input int l, input int go);
        return {gs[0], rn[3:0], tl[5:0], sc[3:0], tr[1:0], w[0], l[0], go[0]};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.game_start, bus.round_num, bus.time_left, bus.score, bus.tries_left,
                bus.round_win, bus.round_lose, bus.game_over};
    endfunction

    function automatic logic [19:0] model_out();
        return ex(int'(m_phase == P_LAUNCH), m_round, RT - m_elapsed / TD, m_score, m_tries,
                  m_win, m_lose, int'(m_phase == P_DONE));
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE; m_elapsed = 0; m_round = 1; m_score = 0; m_tries = MT;
        m_hold = 0; m_win = 0; m_lose = 0;
    endfunction

    function automatic void model_launch();
        m_phase = P_LAUNCH; m_elapsed = 0; m_tries = MT;
    endfunction

    function automatic void model_step(input bit st, input bit sb, input bit scd, input bit cor);
        m_win = 0; m_lose = 0;
        case (m_phase)
            P_IDLE:   if (st) model_launch();
            P_LAUNCH: m_phase = P_WAIT;
            P_WAIT:   if (scd) m_phase = P_PLAY;
            P_PLAY: begin
                if (sb) m_phase = P_JUDGE;
                else begin
                    m_elapsed++;
                    if (m_elapsed == RT * TD) begin m_lose = 1; m_phase = P_RESULT; end
                end
            end
            P_JUDGE: begin
                if (cor) begin
                    m_score = (m_score + 1 > 15) ? 15 : m_score + 1;
                    m_win = 1; m_phase = P_RESULT;
                end else if (m_tries > 1) begin
                    m_tries--; m_phase = P_PLAY;
                end else begin
                    m_tries = 0; m_lose = 1; m_phase = P_RESULT;
                end
            end
            P_RESULT: begin
                m_hold++;
                if (m_hold == RH) begin
                    m_hold = 0;
                    if (m_round == NR) m_phase = P_DONE;
                    else begin m_round++; model_launch(); end
                end
            end
            P_DONE: if (st) begin m_score = 0; m_round = 1; model_launch(); end
            default: m_phase = P_IDLE;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge: drive inputs, let one posedge pass, compare at the next negedge
    task automatic drive_cycle(input bit st, input bit sb, input bit scd, input bit cor);
        bus.start_btn = st; bus.submit_btn = sb; bus.scramble_done = scd; bus.is_correct = cor;
        model_step(st, sb, scd, cor);
        @(negedge clk);
        chk("model", 32'(obs()), 32'(model_out()));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        bus.start_btn = 0; bus.submit_btn = 0; bus.scramble_done = 0; bus.is_correct = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        bit          st, sb, scd, cor;
        logic [19:0] exp;
    } vec_t;
    vec_t tbl[24];

    initial begin
        int k, lose_at, seen;

        tbl[0]  = '{1, 0, 0, 0, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[1]  = '{0, 0, 0, 0, ex(1, 1, 3, 0, 2, 0, 0, 0)};
        tbl[2]  = '{0, 0, 0, 0, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[3]  = '{0, 0, 0, 0, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[4]  = '{0, 1, 0, 0, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[5]  = '{0, 0, 1, 0, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[6]  = '{0, 1, 0, 1, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[7]  = '{0, 0, 0, 1, ex(0, 1, 3, 0, 2, 0, 0, 0)};
        tbl[8]  = '{0, 0, 0, 0, ex(0, 1, 3, 1, 2, 1, 0, 0)};
        tbl[9]  = '{0, 0, 0, 0, ex(0, 1, 3, 1, 2, 0, 0, 0)};
        tbl[10] = '{0, 0, 0, 0, ex(1, 2, 3, 1, 2, 0, 0, 0)};
        tbl[11] = '{0, 0, 1, 0, ex(0, 2, 3, 1, 2, 0, 0, 0)};
        tbl[12] = '{0, 1, 0, 0, ex(0, 2, 3, 1, 2, 0, 0, 0)};
        tbl[13] = '{0, 0, 0, 0, ex(0, 2, 3, 1, 2, 0, 0, 0)};
        tbl[14] = '{0, 0, 0, 0, ex(0, 2, 3, 1, 1, 0, 0, 0)};
        tbl[15] = '{0, 0, 0, 0, ex(0, 2, 3, 1, 1, 0, 0, 0)};
        tbl[16] = '{0, 0, 0, 0, ex(0, 2, 3, 1, 1, 0, 0, 0)};
        tbl[17] = '{0, 0, 0, 0, ex(0, 2, 3, 1, 1, 0, 0, 0)};
        tbl[18] = '{0, 1, 0, 0, ex(0, 2, 2, 1, 1, 0, 0, 0)};
        tbl[19] = '{0, 0, 0, 0, ex(0, 2, 2, 1, 1, 0, 0, 0)};
        tbl[20] = '{0, 0, 0, 0, ex(0, 2, 2, 1, 0, 0, 1, 0)};
        tbl[21] = '{0, 0, 0, 0, ex(0, 2, 2, 1, 0, 0, 0, 0)};
        tbl[22] = '{1, 0, 0, 0, ex(0, 2, 2, 1, 0, 0, 0, 1)};
        tbl[23] = '{0, 0, 0, 0, ex(1, 1, 3, 0, 2, 0, 0, 0)};

        do_reset();
        for (int i = 0; i < 24; i++) begin
            chk($sformatf("table[%0d]", i), 32'(obs()), 32'(tbl[i].exp));
            drive_cycle(tbl[i].st, tbl[i].sb, tbl[i].scd, tbl[i].cor);
        end

        // Timeout: no submits, countdown every TD cycles, lose on the 12th PLAY cycle
        do_reset();
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0);
        lose_at = 0;
        for (k = 1; k <= 20 && lose_at == 0; k++) begin
            drive_cycle(0, 0, 0, 0);
            if (k == 4) chk("tl_after_4", 32'(bus.time_left), 32'd2);
            if (k == 8) chk("tl_after_8", 32'(bus.time_left), 32'd1);
            if (bus.round_lose) lose_at = k;
        end
        chk("timeout_cycle", 32'(lose_at), 32'd12);
        chk("timeout_tl", 32'(bus.time_left), 32'd0);
        seen = 0;
        for (k = 0; k < 6 && !seen; k++) begin
            drive_cycle(0, 0, 0, 0);
            if (bus.game_start) seen = 1;
        end
        chk("round2_launch", 32'(seen), 32'd1);
        chk("round2_num", 32'(bus.round_num), 32'd2);

        // Asynchronous reset in the middle of round 2's PLAY
        drive_cycle(0, 0, 1, 0);
        repeat (5) drive_cycle(0, 0, 0, 0);
        #2 rst = 1'b0;
        #1 chk("async_reset", 32'(obs()), 32'(ex(0, 1, 3, 0, 2, 0, 0, 0)));
        model_reset();
        @(negedge clk);
        repeat (2) drive_cycle(0, 1, 1, 1);
        rst = 1'b1;

        // Submit on the very cycle of the final wrap: judging wins, no timeout lose
        drive_cycle(1, 0, 0, 0);
        drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 0, 1, 0);
        repeat (11) drive_cycle(0, 0, 0, 0);
        drive_cycle(0, 1, 0, 0);
        chk("coincide_no_lose", 32'(bus.round_lose), 32'd0);
        chk("coincide_tl_hold", 32'(bus.time_left), 32'd1);
        drive_cycle(0, 0, 0, 0);
        chk("coincide_judge", 32'({bus.round_lose, bus.tries_left}), 32'({1'b0, 2'd1}));
        drive_cycle(0, 0, 0, 0);
        chk("resumed_timeout", 32'({bus.round_lose, bus.time_left}), 32'({1'b1, 6'd0}));

        do_reset();
        for (int i = 0; i < 3000; i++)
            drive_cycle(($urandom % 8) == 0, ($urandom % 5) == 0, ($urandom % 3) == 0, $urandom % 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
Game-level controller for the word-scramble datapath.
- Sequences a game of NUM_ROUNDS rounds; each round starts with a one-cycle `game_start` pulse to the RNG, scrambler and handler.
- Waits for the scramble to complete, then runs a per-round countdown.
- Judges each player submission from the handler's `is_correct` level and tracks tries, score and round number for the display logic.

Parameters:
- NUM_ROUNDS, 5, rounds per game (1..15)
- ROUND_TIME, 30, seconds per round (1..63)
- TICK_DIV, 50000000, clk cycles per second tick (≥2)
- MAX_TRIES, 3, wrong submissions allowed per round (1..3)
- RESULT_HOLD, 100000000, clk cycles the round result is held before the next round (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- start_btn  in  1  one-cycle pulse, debounced
- submit_btn  in  1  one-cycle pulse, debounced
- scramble_done  in  1  level/pulse from scrambler; scramble ready
- is_correct  in  1  level from handler; current guess matches word
- game_start  out  1  one-cycle pulse; starts RNG/scrambler/handler
- round_num  out  4  current round, 1-based
- time_left  out  6  seconds remaining
- score  out  4  rounds won (saturating)
- tries_left  out  2  remaining wrong submissions
- round_win  out  1  one-cycle pulse
- round_lose  out  1  one-cycle pulse
- game_over  out  1  level, high in DONE

Behaviour:
- Reset (rst=0, async): state=IDLE, game_start=0, round_num=1, time_left=ROUND_TIME, score=0, tries_left=MAX_TRIES, round_win=0, round_lose=0, game_over=0; prescaler=0, hold counter=0. Reset mid-round aborts immediately, with no pulses.
- IDLE: on start_btn go to LAUNCH. Other inputs are ignored.
- LAUNCH (1 cycle):
  - game_start=1 for exactly this cycle.
  - Reload time_left=ROUND_TIME, tries_left=MAX_TRIES, prescaler=0.
  - Next state WAIT_SCR.
- WAIT_SCR: timer frozen; submit_btn ignored; on scramble_done go to PLAY.
- PLAY:
  - The prescaler counts 0..TICK_DIV-1; on wrap time_left decrements.
  - Timeout: the wrap that takes time_left from 1 to 0. On timeout, pulse round_lose and go to RESULT.
  - On submit_btn go to JUDGE. Submit wins over a timeout in the same cycle, and the timer holds that cycle.
- JUDGE (1 cycle; samples is_correct one cycle after submit; timer frozen):
  - Correct: score+1 (saturates at 15), pulse round_win, go to RESULT.
  - Wrong with tries_left>1: tries_left−1, return to PLAY. Prescaler and time_left are preserved, not reloaded.
  - Wrong with tries_left==1: tries_left=0, pulse round_lose, go to RESULT.
- RESULT:
  - Hold RESULT_HOLD cycles; outputs stay stable.
  - Then, if round_num==NUM_ROUNDS, go to DONE (round_num unchanged).
  - Otherwise round_num+1 and go to LAUNCH.
- DONE: game_over=1. On start_btn: score=0, round_num=1, game_over=0, go to LAUNCH.
- start_btn outside IDLE/DONE is ignored.
- round_win/round_lose are never both high, and are each high for exactly one cycle per round.
- Latency: start_btn → game_start is 1 cycle. submit_btn → round_win/round_lose is 2 cycles.

Optional Feature:
SCORE_BONUS_EN
- Defined: a correct JUDGE with time_left ≥ ROUND_TIME/2 (integer divide) and tries_left==MAX_TRIES adds 2 to score, still saturating at 15.
- Undefined: every win adds exactly 1.

Decomposition:
- Package game_pkg: state enum (IDLE, LAUNCH, WAIT_SCR, PLAY, JUDGE, RESULT, DONE) in 3 bits; width constants ROUND_W=4, TIME_W=6, SCORE_W=4, TRIES_W=2; SCORE_MAX=15.
- One sub-module, round_timer: prescaler plus time_left countdown.
  - Inputs: load, run.
  - Outputs: time_left, timeout pulse.
- The FSM, score, tries and round counters stay in round_sequencer.

Test Plan:
All scenarios use TICK_DIV=4, ROUND_TIME=3, NUM_ROUNDS=2, MAX_TRIES=2, RESULT_HOLD=2.

1. Reset, start_btn, then scramble_done 5 cycles later → game_start high exactly 1 cycle after start_btn; time_left=3 and frozen until scramble_done.
2. In PLAY, submit_btn with is_correct=1 → round_win 2 cycles later; score=1; after 2 hold cycles round_num=2 and game_start pulses.
3. In PLAY, two submits with is_correct=0 → tries_left 2→1, then round_lose with tries_left=0; time_left is not reloaded between the submits.
4. No submits → time_left 3→2→1→0 every 4 cycles; round_lose on the 12th PLAY cycle; then round 2 launches.
5. Round 2 ends → DONE with game_over=1 and round_num=2. start_btn → score=0, round_num=1, game_start pulses.
6. Assert rst low mid-PLAY, then submit_btn coincident with the timeout wrap → async reset to IDLE defaults with no pulses. In a separate run, the coincident submit goes to JUDGE and no round_lose fires.
